// File: rtl/slc3_mem_pkg.sv
// Shared types and helpers for the SLC-3 memory-access sequencer.
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic [15:0] DEFAULT_IO_ADDR = 16'hFFFF;

  // Counter width able to hold WAIT_STATES; never narrower than one bit.
  function automatic int unsigned ws_width(input int unsigned ws);
    return (ws < 2) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/slc3_mmio_regs.sv
// Memory-mapped I/O registers: zero-extended switch read path and hex display register.
module slc3_mmio_regs #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SW_W       = 10,
  parameter int unsigned HEX_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SW_W-1:0]         switches,
  input  logic                    hex_we,
  input  logic [4*HEX_DIGITS-1:0] hex_wdata,
  output logic [DATA_W-1:0]       sw_data,
  output logic [4*HEX_DIGITS-1:0] hex_out
);

  logic [4*HEX_DIGITS-1:0] hex_q, hex_d;

  always_comb begin
    sw_data             = '0;
    sw_data[SW_W-1:0]   = switches;
  end

  always_comb begin
    hex_d = hex_q;
    if (hex_we) hex_d = hex_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) hex_q <= '0;
    else       hex_q <= hex_d;
  end

  assign hex_out = hex_q;

endmodule

// File: rtl/slc3_mem_seq.sv
// SLC-3 memory-access sequencer: Req/Ready handshake, registered SRAM strobes with wait states.
// Define MMIO_EN to decode IO_ADDR as the switch/hex register instead of an SRAM location.
module slc3_mem_seq
  import slc3_mem_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(DEFAULT_IO_ADDR),
  parameter int unsigned       SW_W        = 10,
  parameter int unsigned       HEX_DIGITS  = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Req,
  input  logic                    Wr,
  input  logic [ADDR_W-1:0]       Addr_In,
  input  logic [DATA_W-1:0]       Data_In,
  output logic [DATA_W-1:0]       Data_Out,
  output logic                    Ready,
  output logic                    Busy,
  output logic [ADDR_W-1:0]       ADDR,
  output logic [DATA_W-1:0]       Data_to_SRAM,
  input  logic [DATA_W-1:0]       Data_from_SRAM,
  output logic                    OE,
  output logic                    WE,
  input  logic [SW_W-1:0]         Switches,
  output logic [4*HEX_DIGITS-1:0] Hex_Out
);

  localparam int unsigned CNT_W = ws_width(WAIT_STATES);
  localparam int unsigned HEX_W = 4 * HEX_DIGITS;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               oe_q, oe_d;
  logic               we_q, we_d;

  logic               accept;
  logic               is_io;
  logic [DATA_W-1:0]  sw_data;

`ifdef MMIO_EN
  assign is_io = (Addr_In == IO_ADDR);

  slc3_mmio_regs #(
    .DATA_W     (DATA_W),
    .SW_W       (SW_W),
    .HEX_DIGITS (HEX_DIGITS)
  ) u_mmio (
    .clk       (Clk),
    .reset     (Reset),
    .switches  (Switches),
    .hex_we    (accept && is_io && Wr),
    .hex_wdata (Data_In[HEX_W-1:0]),
    .sw_data   (sw_data),
    .hex_out   (Hex_Out)
  );
`else
  logic unused_switches;

  assign is_io           = 1'b0;
  assign sw_data         = '0;
  assign Hex_Out         = '0;
  assign unused_switches = ^Switches;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    accept  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (Req) begin
          accept  = 1'b1;
          addr_d  = Addr_In;
          wdata_d = Data_In;
          op_d    = Wr ? OP_WR : OP_RD;
          if (is_io) begin
            state_d = DONE;
            if (!Wr) rdata_d = sw_data;
          end else begin
            state_d = STROBE;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end else begin
          state_d = IDLE;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (op_q == OP_RD) rdata_d = Data_from_SRAM;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes follow the next state so they are registered yet aligned with STROBE.
    oe_d = !((state_d == STROBE) && (op_d == OP_RD));
    we_d = !((state_d == STROBE) && (op_d == OP_WR));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
    end
  end

  assign Ready        = (state_q == DONE);
  assign Busy         = (state_q == STROBE);
  assign ADDR         = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign Data_Out     = rdata_q;
  assign OE           = oe_q;
  assign WE           = we_q;

endmodule
